// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 access encodings, responder FSM states,
// and a legality check for funct3 by access direction.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

    // RISC-V load/store funct3 encodings (store only uses B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !wr;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment for a 32-bit word RAM: store byte enables/lane data and load extension.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
//  funct3     in  3   access size/sign
//  addr_lo    in  2   byte offset within the word
//  wdata      in  32  low-aligned store data
//  raw_word   in  32  word read from RAM
//  byte_en    out 4   store byte enables
//  lane_wdata out 32  store data replicated onto the enabled lanes
//  misalign   out 1   halfword/word access not naturally aligned
//  load_data  out 32  selected lane, sign/zero extended
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = wdata;
        misalign   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            F3_W: begin
                byte_en  = 4'b1111;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = raw_word[7:0];
            2'd1:    byte_v = raw_word[15:8];
            2'd2:    byte_v = raw_word[23:16];
            default: byte_v = raw_word[31:24];
        endcase
        half_v = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_W:    load_data = raw_word;
            F3_BU:   load_data = {24'd0, byte_v};
            F3_HU:   load_data = {16'd0, half_v};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: sized loads/stores on an internal word RAM with error reporting.
// Latency: accept edge to resp_valid = LATENCY+1 cycles; one transaction in flight.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
//  clk, rst_n                    clock, async active-low reset
//  req_valid/req_ready           request handshake
//  req_write/funct3/addr/wdata   request fields (byte address, low-aligned data)
//  resp_valid/resp_ready         response handshake
//  resp_rdata/resp_err           extended load data (0 on store/error), error flag
module data_mem_resp
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**ADDR_W];

    // With LATENCY=0 the access happens on the accept edge itself, so the
    // live request fields are used while IDLE and the captured ones otherwise.
    logic              in_idle, accept, go_resp;
    logic              acc_wr, acc_err, mem_we;
    logic [2:0]        acc_f3;
    logic [31:0]       acc_addr, acc_wdata;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       raw_word, lane_wdata, load_data;
    logic [3:0]        byte_en;
    logic              misalign;

    assign in_idle   = (state_q == IDLE);
    assign accept    = in_idle && req_valid;
    assign go_resp   = ((state_q == WAIT) && (cnt_q == 4'd0)) || ((LATENCY == 0) && accept);
    assign acc_wr    = in_idle ? req_write  : wr_q;
    assign acc_f3    = in_idle ? req_funct3 : f3_q;
    assign acc_addr  = in_idle ? req_addr   : addr_q;
    assign acc_wdata = in_idle ? req_wdata  : wdata_q;
    assign word_idx  = acc_addr[ADDR_W+1:2];
    assign raw_word  = mem[word_idx];

    mem_lane_align u_align (
        .funct3     (acc_f3),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .misalign   (misalign),
        .load_data  (load_data)
    );

    assign acc_err = misalign || !f3_legal(acc_wr, acc_f3) || (|acc_addr[31:ADDR_W+2]);
    // rst_n gate keeps a zero-latency store presented during reset from landing.
    assign mem_we  = go_resp && acc_wr && !acc_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            rdata_d = (acc_wr || acc_err) ? 32'd0 : load_data;
            err_d   = acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a LATENCY=2 and a LATENCY=0 instance, each checked
// against a byte-array memory model driven by directed and random transactions.
module tb_data_mem_resp;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq_write;
    logic [2:0]  rq_funct3;
    logic [31:0] rq_addr, rq_wdata;
    logic        rq_valid   [2];
    logic        rs_ready   [2];
    logic        rq_ready_o [2];
    logic        rs_valid_o [2];
    logic        rs_err_o   [2];
    logic [31:0] rs_rdata_o [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [2][4096];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    data_mem_resp #(.ADDR_W(10), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rq_valid[0]), .req_ready(rq_ready_o[0]),
        .req_write(rq_write), .req_funct3(rq_funct3), .req_addr(rq_addr), .req_wdata(rq_wdata),
        .resp_valid(rs_valid_o[0]), .resp_ready(rs_ready[0]),
        .resp_rdata(rs_rdata_o[0]), .resp_err(rs_err_o[0])
    );

    data_mem_resp #(.ADDR_W(10), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rq_valid[1]), .req_ready(rq_ready_o[1]),
        .req_write(rq_write), .req_funct3(rq_funct3), .req_addr(rq_addr), .req_wdata(rq_wdata),
        .resp_valid(rs_valid_o[1]), .resp_ready(rs_ready[1]),
        .resp_rdata(rs_rdata_o[1]), .resp_err(rs_err_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte-addressed memory of 4 KiB per instance; sizes 1/2/4 bytes, little endian.
    function automatic void model(input int sel, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int size;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        err = (size == 0) || (wr && f3[2]) || (addr >= 32'd4096);
        if (!err && (addr % size) != 0) err = 1'b1;
        rd = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < size; i++) ref_mem[sel][addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[sel][addr + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endfunction

    task automatic txn(input int sel, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model(sel, wr, f3, addr, wd, exp_rd, exp_err);
        @(posedge clk); #1;
        rq_write = wr; rq_funct3 = f3; rq_addr = addr; rq_wdata = wd;
        rq_valid[sel] = 1'b1;
        chk("req_ready_idle", 32'(rq_ready_o[sel]), 32'd1);
        @(posedge clk); #1;
        // Keep valid asserted with junk fields: must be ignored while busy.
        rq_write  = 1'($urandom);
        rq_funct3 = 3'($urandom);
        rq_addr   = $urandom_range(0, 127);
        rq_wdata  = $urandom;
        lat = 1;
        while (!rs_valid_o[sel] && lat < 40) begin
            chk("busy_req_ready", 32'(rq_ready_o[sel]), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (sel == 0) ? 32'd3 : 32'd1);
        chk("rdata", rs_rdata_o[sel], exp_rd);
        chk("err", 32'(rs_err_o[sel]), 32'(exp_err));
        last_rdata = rs_rdata_o[sel];
        last_err   = rs_err_o[sel];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rs_valid_o[sel]), 32'd1);
            chk("hold_rdata", rs_rdata_o[sel], exp_rd);
            chk("hold_err", 32'(rs_err_o[sel]), 32'(exp_err));
            chk("hold_req_ready", 32'(rq_ready_o[sel]), 32'd0);
        end
        rq_valid[sel] = 1'b0;
        rs_ready[sel] = 1'b1;
        @(posedge clk); #1;
        rs_ready[sel] = 1'b0;
        chk("post_valid", 32'(rs_valid_o[sel]), 32'd0);
        chk("post_req_ready", 32'(rq_ready_o[sel]), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        rq_write = 1'b0; rq_funct3 = 3'd0; rq_addr = 32'd0; rq_wdata = 32'd0;
        for (int s = 0; s < 2; s++) begin
            rq_valid[s] = 1'b0;
            rs_ready[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready", 32'(rq_ready_o[s]), 32'd1);
            chk("rst_resp_valid", 32'(rs_valid_o[s]), 32'd0);
            chk("rst_rdata", rs_rdata_o[s], 32'd0);
            chk("rst_err", 32'(rs_err_o[s]), 32'd0);
        end
        rst_n = 1'b1;

        // Give the low 128 bytes of both RAMs known contents.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 32; w++) txn(s, 1'b1, F3_W, 32'(w * 4), $urandom, 0);

        txn(0, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0);
        txn(0, 1'b0, F3_W, 32'h10, 32'd0, 0);
        chk("lw_deadbeef", last_rdata, 32'hDEAD_BEEF);
        txn(0, 1'b1, F3_B, 32'h13, 32'h0000_0080, 0);
        txn(0, 1'b0, F3_B, 32'h13, 32'd0, 0);
        chk("lb_sext", last_rdata, 32'hFFFF_FF80);
        txn(0, 1'b0, F3_BU, 32'h13, 32'd0, 0);
        chk("lbu_zext", last_rdata, 32'h0000_0080);
        txn(0, 1'b0, F3_W, 32'h10, 32'd0, 0);
        chk("sb_lane_only", last_rdata, 32'h80AD_BEEF);
        txn(0, 1'b0, F3_H, 32'h11, 32'd0, 0);
        chk("lh_misalign_err", 32'(last_err), 32'd1);
        chk("lh_misalign_rdata", last_rdata, 32'd0);
        txn(0, 1'b1, F3_W, 32'h11, 32'h1111_1111, 0);
        chk("sw_misalign_err", 32'(last_err), 32'd1);
        txn(0, 1'b0, F3_W, 32'h10, 32'd0, 0);
        chk("sw_misalign_nowrite", last_rdata, 32'h80AD_BEEF);
        txn(0, 1'b0, 3'b011, 32'h10, 32'd0, 0);
        chk("illegal_f3_err", 32'(last_err), 32'd1);
        txn(0, 1'b0, F3_W, 32'h10, 32'd0, 5);

        // Reset while a store waits: it must never reach the RAM.
        @(posedge clk); #1;
        rq_write = 1'b1; rq_funct3 = F3_W; rq_addr = 32'h20; rq_wdata = 32'h1234_5678;
        rq_valid[0] = 1'b1;
        @(posedge clk); #1;
        rq_valid[0] = 1'b0;
        chk("wait_req_ready", 32'(rq_ready_o[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(rq_ready_o[0]), 32'd1);
        chk("midrst_resp_valid", 32'(rs_valid_o[0]), 32'd0);
        chk("midrst_rdata", rs_rdata_o[0], 32'd0);
        chk("midrst_err", 32'(rs_err_o[0]), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        txn(0, 1'b0, F3_W, 32'h20, 32'd0, 0);

        txn(1, 1'b1, F3_W, 32'h4, 32'hCAFE_F00D, 0);
        txn(1, 1'b0, F3_W, 32'h4, 32'd0, 0);
        chk("l0_lw", last_rdata, 32'hCAFE_F00D);
        txn(1, 1'b0, F3_W, 32'h1000, 32'd0, 0);
        chk("l0_range_err", 32'(last_err), 32'd1);
        txn(0, 1'b0, F3_W, 32'h1000, 32'd0, 0);
        chk("l2_range_err", 32'(last_err), 32'd1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom | 32'h0000_1000;
                1:       a = 32'h1000 + $urandom_range(0, 15);
                default: a = $urandom_range(0, 127);
            endcase
            txn(int'($urandom_range(0, 1)), 1'($urandom), 3'($urandom), a, $urandom,
                int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
